// File: rtl/uart_rx.sv
// Asynchronous serial receiver: 8 data bits LSB first, check bit and two stop bits,
// sampled mid-bit from an internal baud divider and delivered on a valid/ready port.
module uart_rx #(
   parameter int unsigned CLK_DIV = 434
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       parity_i,
   input  logic [1:0] stopbit_i,
   input  logic       rs422_rx_i,
   output logic [7:0] rx_data_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic       parity_err_o,
   output logic       frame_err_o,
   output logic       overrun_o
);

   localparam int unsigned CntW = $clog2(CLK_DIV);
   localparam logic [CntW-1:0] HalfLoad = CntW'(CLK_DIV / 2 - 1);
   localparam logic [CntW-1:0] FullLoad = CntW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StCheck,
      StStop0,
      StStop1
   } state_e;

   state_e state_q, state_d;

   logic            sync1_q, rxs_q, rxs_dly_q;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            chk_err_q, chk_err_d;
   logic            stop0_err_q, stop0_err_d;
   logic [7:0]      rx_data_q, rx_data_d;
   logic            valid_q, valid_d;
   logic            perr_q, perr_d;
   logic            ferr_q, ferr_d;
   logic            ovr_q, ovr_d;

   logic fall, tick, commit;

   assign fall = rxs_dly_q & ~rxs_q;
   assign tick = (cnt_q == '0);

   // Synchronizer plus edge-detect stage; idle-high reset avoids a spurious start.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q   <= 1'b1;
         rxs_q     <= 1'b1;
         rxs_dly_q <= 1'b1;
      end else begin
         sync1_q   <= rs422_rx_i;
         rxs_q     <= sync1_q;
         rxs_dly_q <= rxs_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (fall) state_d = StStart;
         StStart: if (tick) state_d = rxs_q ? StIdle : StData;
         StData:  if (tick && idx_q == 3'd7) state_d = StCheck;
         StCheck: if (tick) state_d = StStop0;
         StStop0: if (tick) state_d = StStop1;
         StStop1: if (tick) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      chk_err_d   = chk_err_q;
      stop0_err_d = stop0_err_q;
      commit      = 1'b0;

      if (state_q != StIdle) begin
         cnt_d = tick ? FullLoad : cnt_q - 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (fall) cnt_d = HalfLoad;
         end
         StStart: begin
            if (tick) idx_d = 3'd0;
         end
         StData: begin
            if (tick) begin
               shift_d[idx_q] = rxs_q;
               idx_d          = idx_q + 3'd1;
            end
         end
         StCheck: begin
            if (tick) chk_err_d = rxs_q ^ (parity_i ? ^shift_q : ~^shift_q);
         end
         StStop0: begin
            if (tick) stop0_err_d = rxs_q ^ stopbit_i[0];
         end
         StStop1: begin
            if (tick) commit = 1'b1;
         end
         default: ;
      endcase

      rx_data_d = commit ? shift_q : rx_data_q;
      perr_d    = commit ? chk_err_q : perr_q;
      ferr_d    = commit ? (stop0_err_q | (rxs_q ^ stopbit_i[1])) : ferr_q;
      // A commit wins over the handshake; losing an unconsumed byte flags overrun.
      valid_d   = commit | (valid_q & ~ready_i);
      ovr_d     = commit & valid_q & ~ready_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q       <= '0;
         idx_q       <= 3'd0;
         shift_q     <= 8'h00;
         chk_err_q   <= 1'b0;
         stop0_err_q <= 1'b0;
         rx_data_q   <= 8'h00;
         valid_q     <= 1'b0;
         perr_q      <= 1'b0;
         ferr_q      <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         chk_err_q   <= chk_err_d;
         stop0_err_q <= stop0_err_d;
         rx_data_q   <= rx_data_d;
         valid_q     <= valid_d;
         perr_q      <= perr_d;
         ferr_q      <= ferr_d;
         ovr_q       <= ovr_d;
      end
   end

   assign rx_data_o    = rx_data_q;
   assign valid_o      = valid_q;
   assign parity_err_o = perr_q;
   assign frame_err_o  = ferr_q;
   assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives serial frames, queues the expected byte and error
// flags per frame, and checks them when valid rises.
module tb_uart_rx;

   localparam int unsigned Div = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       parity;
   logic [1:0] stopbit;
   logic       line;
   logic [7:0] rx_data;
   logic       valid;
   logic       ready;
   logic       perr;
   logic       ferr;
   logic       ovr;

   typedef struct packed {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp   = 0;
   int   n_err   = 0;
   int   ovr_cnt = 0;
   int   base;

   uart_rx #(.CLK_DIV(Div)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .parity_i    (parity),
      .stopbit_i   (stopbit),
      .rs422_rx_i  (line),
      .rx_data_o   (rx_data),
      .valid_o     (valid),
      .ready_i     (ready),
      .parity_err_o(perr),
      .frame_err_o (ferr),
      .overrun_o   (ovr)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (ovr === 1'b1) ovr_cnt++;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic good_chk(input logic [7:0] d);
      return parity ? ^d : ~^d;
   endfunction

   // Expected outcome computed from what is put on the line and the current config.
   task automatic push(input logic [7:0] d, input logic c, input logic s0, input logic s1);
      exp_t e;
      e.data = d;
      e.perr = (c != good_chk(d));
      e.ferr = (s0 != stopbit[0]) || (s1 != stopbit[1]);
      sb_q.push_back(e);
   endtask

   task automatic send(input logic [7:0] d, input logic c, input logic s0, input logic s1);
      logic [11:0] bits;
      bits = {s1, s0, c, d, 1'b0};
      for (int j = 0; j < 12; j++) begin
         @(negedge clk) line = bits[j];
         repeat (Div - 1) @(negedge clk);
      end
      @(negedge clk) line = 1'b1;
   endtask

   task automatic check_frame(input string tag);
      exp_t e;
      for (int i = 0; i < 400 && valid !== 1'b1; i++) @(negedge clk);
      chk({tag, "_valid"}, {7'd0, valid}, 8'd1);
      if (sb_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 8'd0, 8'd1);
      end else begin
         e = sb_q.pop_front();
         chk({tag, "_data"}, rx_data, e.data);
         chk({tag, "_perr"}, {7'd0, perr}, {7'd0, e.perr});
         chk({tag, "_ferr"}, {7'd0, ferr}, {7'd0, e.ferr});
      end
   endtask

   task automatic consume(input string tag);
      @(negedge clk) ready = 1'b1;
      @(negedge clk) ready = 1'b0;
      chk({tag, "_ack"}, {7'd0, valid}, 8'd0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_data"}, rx_data, 8'h00);
      chk({tag, "_valid"}, {7'd0, valid}, 8'd0);
      chk({tag, "_perr"}, {7'd0, perr}, 8'd0);
      chk({tag, "_ferr"}, {7'd0, ferr}, 8'd0);
      chk({tag, "_ovr"}, {7'd0, ovr}, 8'd0);
   endtask

   initial begin
      logic [7:0] part;
      rst_n   = 1'b0;
      line    = 1'b1;
      ready   = 1'b0;
      parity  = 1'b1;
      stopbit = 2'b11;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Good frame, then hold with ready low
      push(8'hA5, good_chk(8'hA5), 1'b1, 1'b1);
      send(8'hA5, good_chk(8'hA5), 1'b1, 1'b1);
      check_frame("good");
      repeat (20) @(negedge clk);
      chk("good_hold_valid", {7'd0, valid}, 8'd1);
      chk("good_hold_data", rx_data, 8'hA5);
      consume("good");

      // Parity error: check bit opposite to ~^8'h01
      parity = 1'b0;
      push(8'h01, ~good_chk(8'h01), 1'b1, 1'b1);
      send(8'h01, ~good_chk(8'h01), 1'b1, 1'b1);
      check_frame("perr");
      consume("perr");

      // Frame error on the second stop bit
      parity = 1'b1;
      push(8'h3C, good_chk(8'h3C), 1'b1, 1'b0);
      send(8'h3C, good_chk(8'h3C), 1'b1, 1'b0);
      check_frame("ferr");
      consume("ferr");

      // Mixed stop-bit configuration, no error
      stopbit = 2'b10;
      push(8'h96, good_chk(8'h96), 1'b0, 1'b1);
      send(8'h96, good_chk(8'h96), 1'b0, 1'b1);
      check_frame("stop10");
      consume("stop10");
      stopbit = 2'b11;

      // False start
      @(negedge clk) line = 1'b0;
      repeat (4) @(negedge clk);
      line = 1'b1;
      repeat (40) @(negedge clk);
      chk("fs_novalid", {7'd0, valid}, 8'd0);
      push(8'h55, good_chk(8'h55), 1'b1, 1'b1);
      send(8'h55, good_chk(8'h55), 1'b1, 1'b1);
      check_frame("fs_next");
      consume("fs_next");

      // Overrun: second byte overwrites the first
      base = ovr_cnt;
      push(8'h22, good_chk(8'h22), 1'b1, 1'b1);
      send(8'h11, good_chk(8'h11), 1'b1, 1'b1);
      send(8'h22, good_chk(8'h22), 1'b1, 1'b1);
      check_frame("ovr");
      chk("ovr_pulses", 8'(ovr_cnt - base), 8'd1);
      consume("ovr");

      // ready high exactly in the commit cycle of the second byte (187 clocks after the edge)
      push(8'h11, good_chk(8'h11), 1'b1, 1'b1);
      send(8'h11, good_chk(8'h11), 1'b1, 1'b1);
      check_frame("rdy_first");
      base = ovr_cnt;
      push(8'h22, good_chk(8'h22), 1'b1, 1'b1);
      fork
         send(8'h22, good_chk(8'h22), 1'b1, 1'b1);
         begin
            wait (line == 1'b0);
            repeat (186) @(posedge clk);
            @(negedge clk) ready = 1'b1;
            @(negedge clk) ready = 1'b0;
         end
      join
      check_frame("rdy_commit");
      chk("rdy_no_ovr", 8'(ovr_cnt - base), 8'd0);

      // Reset during data bit 4 with a byte still pending
      part = 8'h3C;
      @(negedge clk) line = 1'b0;
      repeat (Div - 1) @(negedge clk);
      for (int j = 0; j < 4; j++) begin
         @(negedge clk) line = part[j];
         repeat (Div - 1) @(negedge clk);
      end
      @(negedge clk) line = part[4];
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      line  = 1'b1;
      repeat (2) @(negedge clk);
      check_zero("rst_mid");
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("rst_no_partial", {7'd0, valid}, 8'd0);
      push(8'hF0, good_chk(8'hF0), 1'b1, 1'b1);
      send(8'hF0, good_chk(8'hF0), 1'b1, 1'b1);
      check_frame("after_rst");
      consume("after_rst");
      chk("sb_drained", 8'(sb_q.size()), 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
